// File: rtl/mipi_csi_tx_packet_builder.sv
// -----------------------------------------------------------------------------
// mipi_csi_tx_packet_builder
//
// Transmit-side CSI-2 low-level packet builder. It takes one packet request
// (virtual channel, data type, word count) and emits the packet as a byte
// stream:
//   short packet (dt 0x00-0x0F): DataID, WC LSB, WC MSB, ECC
//   long packet  (dt 0x10-0x3F): DataID, WC LSB, WC MSB, ECC,
//                                wc payload bytes, footer LSB, footer MSB
// The 6-bit header ECC is computed so that the RX header decoder sees a zero
// syndrome.
//
// Configuration macro: MIPI_CSI_TX_CRC_EN
//   defined   : footer is CRC-16 (poly 0x8408 reflected, seed 0xFFFF, LSB-first,
//               no final XOR) over the payload bytes.
//   undefined : footer is 0x00 0x00 and no CRC logic exists.
//
// Handshakes: every channel uses valid/ready. A transfer happens on a rising
// clock edge where valid and ready are both high. A source holds its data
// stable while valid is high and ready is low; a sink may raise or drop ready
// at any time.
//
// Ports:
//   clk_i         in   clock
//   reset_n_i     in   asynchronous active-low reset
//   req_valid_i   in   packet request valid
//   req_ready_o   out  request ready (high only in IDLE)
//   req_vc_i      in   [1:0]  virtual channel
//   req_dt_i      in   [5:0]  data type
//   req_wc_i      in   [15:0] word count / short-packet data field
//   pld_valid_i   in   payload byte valid
//   pld_ready_o   out  payload byte ready (only in PLD)
//   pld_data_i    in   [7:0]  payload byte
//   byte_valid_o  out  output byte valid (registered)
//   byte_ready_i  in   downstream ready
//   byte_data_o   out  [7:0]  output byte (registered)
//   byte_last_o   out  final byte of packet (registered)
//   dbg_state_o   out  [1:0]  current FSM state (0 IDLE, 1 HDR, 2 PLD, 3 FTR)
// -----------------------------------------------------------------------------
module mipi_csi_tx_packet_builder (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [1:0]  req_vc_i,
  input  logic [5:0]  req_dt_i,
  input  logic [15:0] req_wc_i,
  input  logic        pld_valid_i,
  output logic        pld_ready_o,
  input  logic [7:0]  pld_data_i,
  output logic        byte_valid_o,
  input  logic        byte_ready_i,
  output logic [7:0]  byte_data_o,
  output logic        byte_last_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_PLD  = 2'd2,
    ST_FTR  = 2'd3
  } state_e;

  // Header ECC over D[23:0] = {wc[15:8], wc[7:0], vc, dt}.
  function automatic logic [5:0] calc_ecc(input logic [23:0] d);
    logic [5:0] e;
    e[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^
           d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    e[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^
           d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    e[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^
           d[18] ^ d[20] ^ d[21] ^ d[22];
    e[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^
           d[19] ^ d[20] ^ d[21] ^ d[23];
    e[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^
           d[19] ^ d[20] ^ d[22] ^ d[23];
    e[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^
           d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
    return e;
  endfunction

`ifdef MIPI_CSI_TX_CRC_EN
  // One payload byte into the reflected CRC-16 (LSB of the byte first).
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc,
                                             input logic [7:0]  b);
    logic [15:0] c;
    c = crc ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) c = {1'b0, c[15:1]} ^ 16'h8408;
      else      c = {1'b0, c[15:1]};
    end
    return c;
  endfunction
`endif

  // State and datapath registers
  state_e      state_q,     state_d;
  logic        req_ready_q, req_ready_d;
  logic [1:0]  vc_q,        vc_d;
  logic [5:0]  dt_q,        dt_d;
  logic [15:0] wc_q,        wc_d;
  logic [5:0]  ecc_q,       ecc_d;
  logic [1:0]  hdr_idx_q,   hdr_idx_d;   // header byte currently in the output register
  logic [15:0] cnt_q,       cnt_d;       // payload bytes still to accept
  logic [1:0]  ftr_idx_q,   ftr_idx_d;   // footer bytes loaded so far
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q,  out_data_d;
  logic        out_last_q,  out_last_d;

  logic        is_long;
  logic        out_take;
  logic        out_free;
  logic        pld_take;
  logic [7:0]  ftr_lsb;
  logic [7:0]  ftr_msb;

`ifdef MIPI_CSI_TX_CRC_EN
  logic [15:0] crc_q, crc_d;
  assign ftr_lsb = crc_q[7:0];
  assign ftr_msb = crc_q[15:8];
`else
  assign ftr_lsb = 8'h00;
  assign ftr_msb = 8'h00;
`endif

  // Data types 0x10 and above are long packets.
  assign is_long  = |dt_q[5:4];
  assign out_take = out_valid_q && byte_ready_i;
  // The output register can take a new byte this cycle.
  assign out_free = !out_valid_q || byte_ready_i;
  assign pld_take = (state_q == ST_PLD) && out_free && pld_valid_i;

  always_comb begin
    state_d     = state_q;
    vc_d        = vc_q;
    dt_d        = dt_q;
    wc_d        = wc_q;
    ecc_d       = ecc_q;
    hdr_idx_d   = hdr_idx_q;
    cnt_d       = cnt_q;
    ftr_idx_d   = ftr_idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
`ifdef MIPI_CSI_TX_CRC_EN
    crc_d       = crc_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          vc_d        = req_vc_i;
          dt_d        = req_dt_i;
          wc_d        = req_wc_i;
          ecc_d       = calc_ecc({req_wc_i, req_vc_i, req_dt_i});
          hdr_idx_d   = 2'd0;
          cnt_d       = 16'd0;
          ftr_idx_d   = 2'd0;
          // DataID goes straight into the output register so it appears the
          // cycle after accept.
          out_valid_d = 1'b1;
          out_data_d  = {req_vc_i, req_dt_i};
          out_last_d  = 1'b0;
`ifdef MIPI_CSI_TX_CRC_EN
          crc_d       = 16'hFFFF;
`endif
          state_d     = ST_HDR;
        end
      end

      ST_HDR: begin
        if (out_take) begin
          case (hdr_idx_q)
            2'd0: begin
              out_data_d = wc_q[7:0];
              hdr_idx_d  = 2'd1;
            end
            2'd1: begin
              out_data_d = wc_q[15:8];
              hdr_idx_d  = 2'd2;
            end
            2'd2: begin
              out_data_d = {2'b00, ecc_q};
              out_last_d = !is_long;
              hdr_idx_d  = 2'd3;
            end
            default: begin
              // ECC byte accepted.
              out_valid_d = 1'b0;
              out_data_d  = 8'h00;
              out_last_d  = 1'b0;
              if (!is_long) begin
                state_d = ST_IDLE;
              end else if (wc_q == 16'd0) begin
                ftr_idx_d = 2'd0;
                state_d   = ST_FTR;
              end else begin
                cnt_d   = wc_q;
                state_d = ST_PLD;
              end
            end
          endcase
        end
      end

      ST_PLD: begin
        if (pld_take) begin
          out_valid_d = 1'b1;
          out_data_d  = pld_data_i;
          out_last_d  = 1'b0;
          cnt_d       = cnt_q - 16'd1;
`ifdef MIPI_CSI_TX_CRC_EN
          crc_d       = crc16_byte(crc_q, pld_data_i);
`endif
          if (cnt_q == 16'd1) begin
            ftr_idx_d = 2'd0;
            state_d   = ST_FTR;
          end
        end else if (out_take) begin
          out_valid_d = 1'b0;
          out_data_d  = 8'h00;
        end
      end

      ST_FTR: begin
        if (ftr_idx_q == 2'd2) begin
          if (out_take) begin
            out_valid_d = 1'b0;
            out_data_d  = 8'h00;
            out_last_d  = 1'b0;
            state_d     = ST_IDLE;
          end
        end else if (out_free) begin
          // Loads the footer as soon as the last payload byte leaves, so
          // there is no bubble between payload and footer.
          out_valid_d = 1'b1;
          out_data_d  = (ftr_idx_q == 2'd0) ? ftr_lsb : ftr_msb;
          out_last_d  = (ftr_idx_q == 2'd1);
          ftr_idx_d   = ftr_idx_q + 2'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Ready is registered: it rises the cycle after the FSM re-enters IDLE.
    req_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      req_ready_q <= 1'b0;
      vc_q        <= 2'd0;
      dt_q        <= 6'd0;
      wc_q        <= 16'd0;
      ecc_q       <= 6'd0;
      hdr_idx_q   <= 2'd0;
      cnt_q       <= 16'd0;
      ftr_idx_q   <= 2'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_last_q  <= 1'b0;
`ifdef MIPI_CSI_TX_CRC_EN
      crc_q       <= 16'hFFFF;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      vc_q        <= vc_d;
      dt_q        <= dt_d;
      wc_q        <= wc_d;
      ecc_q       <= ecc_d;
      hdr_idx_q   <= hdr_idx_d;
      cnt_q       <= cnt_d;
      ftr_idx_q   <= ftr_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
`ifdef MIPI_CSI_TX_CRC_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign req_ready_o  = req_ready_q;
  assign pld_ready_o  = (state_q == ST_PLD) && out_free;
  assign byte_valid_o = out_valid_q;
  assign byte_data_o  = out_data_q;
  assign byte_last_o  = out_last_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mipi_csi_tx_packet_builder.sv
// -----------------------------------------------------------------------------
// Bench for mipi_csi_tx_packet_builder. Expected bytes are hand-derived header
// and footer values pushed into exp_q; a monitor pops one entry per accepted
// output byte and checks that stalled output bytes stay stable.
// -----------------------------------------------------------------------------
module tb_mipi_csi_tx_packet_builder;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_vc_i;
  logic [5:0]  req_dt_i;
  logic [15:0] req_wc_i;
  logic        pld_valid_i;
  logic        pld_ready_o;
  logic [7:0]  pld_data_i;
  logic        byte_valid_o;
  logic        byte_ready_i;
  logic [7:0]  byte_data_o;
  logic        byte_last_o;
  logic [1:0]  dbg_state_o;

  mipi_csi_tx_packet_builder dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_vc_i     (req_vc_i),
    .req_dt_i     (req_dt_i),
    .req_wc_i     (req_wc_i),
    .pld_valid_i  (pld_valid_i),
    .pld_ready_o  (pld_ready_o),
    .pld_data_i   (pld_data_i),
    .byte_valid_o (byte_valid_o),
    .byte_ready_i (byte_ready_i),
    .byte_data_o  (byte_data_o),
    .byte_last_o  (byte_last_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- bookkeeping ----------------
  int          total = 0;
  int          bad   = 0;
  logic [8:0]  exp_q[$];          // {last, data}
  logic [7:0]  pld_mem [0:639];
  logic        rdy_rand = 1'b0;
  logic        mon_en   = 1'b0;
  logic        abort    = 1'b0;
  int          byte_n   = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Bit-serial reflected CRC-16 reference over pld_mem[0..n-1].
  function automatic logic [15:0] crc_ref(input int n);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ pld_mem[i][b];
        c  = {1'b0, c[15:1]};
        if (fb) c = c ^ 16'h8408;
      end
    end
    return c;
  endfunction

  function automatic logic [15:0] exp_footer(input int n);
`ifdef MIPI_CSI_TX_CRC_EN
    return crc_ref(n);
`else
    return (n < 0) ? 16'hFFFF : 16'h0000;
`endif
  endfunction

  // ---------------- downstream ready driver ----------------
  initial begin
    byte_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      byte_ready_i = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic       held;
    logic [7:0] held_data;
    logic       held_last;
    logic [8:0] e;
    held = 1'b0;
    held_data = 8'h00;
    held_last = 1'b0;
    forever begin
      @(negedge clk_i);
      if (reset_n_i && mon_en) begin
        if (held) begin
          check("hold_valid", 32'(byte_valid_o), 32'd1);
          check("hold_data",  32'(byte_data_o),  32'(held_data));
          check("hold_last",  32'(byte_last_o),  32'(held_last));
        end
        if (byte_valid_o && byte_ready_i) begin
          if (exp_q.size() == 0) begin
            check("extra_byte", 32'(exp_q.size()), 32'd1);
          end else begin
            e = exp_q.pop_front();
            check($sformatf("byte%0d", byte_n), 32'({byte_last_o, byte_data_o}),
                  32'(e));
            byte_n++;
          end
        end
        held      = byte_valid_o && !byte_ready_i;
        held_data = byte_data_o;
        held_last = byte_last_o;
      end else begin
        held = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input logic [7:0] d, input logic last);
    exp_q.push_back({last, d});
  endtask

  task automatic push_hdr(input logic [7:0] id, input logic [15:0] wc,
                          input logic [7:0] ecc, input logic last);
    push(id, 1'b0);
    push(wc[7:0], 1'b0);
    push(wc[15:8], 1'b0);
    push(ecc, last);
  endtask

  task automatic push_long(input logic [7:0] id, input logic [15:0] wc,
                           input logic [7:0] ecc, input logic [15:0] ftr);
    push_hdr(id, wc, ecc, 1'b0);
    for (int i = 0; i < int'(wc); i++) push(pld_mem[i], 1'b0);
    push(ftr[7:0], 1'b0);
    push(ftr[15:8], 1'b1);
  endtask

  // Called at posedge+1; returns at posedge+1 one cycle after acceptance.
  task automatic send_req(input logic [1:0] vc, input logic [5:0] dt,
                          input logic [15:0] wc);
    int n;
    req_vc_i    = vc;
    req_dt_i    = dt;
    req_wc_i    = wc;
    req_valid_i = 1'b1;
    n = 0;
    while (!req_ready_o && n < 50) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check("req_ready_seen", 32'(req_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
    check("lat_valid",  32'(byte_valid_o), 32'd1);
    check("lat_dataid", 32'(byte_data_o),  32'({vc, dt}));
    check("req_busy",   32'(req_ready_o),  32'd0);
  endtask

  task automatic send_pld(input int n, input logic stall);
    int   guard;
    logic took;
    for (int i = 0; i < n && !abort; i++) begin
      pld_data_i = pld_mem[i];
      guard = 0;
      took  = 1'b0;
      while (!took && guard < 4000 && !abort) begin
        pld_valid_i = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
        @(negedge clk_i);
        took = pld_valid_i && pld_ready_o;
        @(posedge clk_i);
        #1;
        guard++;
      end
    end
    pld_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_idle_rdy"}, 32'(req_ready_o), 32'd1);
    check({tag, "_idle_vld"}, 32'(byte_valid_o), 32'd0);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] vec24 [0:23];
    logic [15:0] f;
    vec24 = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
              8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
              8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

    reset_n_i   = 1'b0;
    req_valid_i = 1'b0;
    req_vc_i    = 2'd0;
    req_dt_i    = 6'd0;
    req_wc_i    = 16'd0;
    pld_valid_i = 1'b0;
    pld_data_i  = 8'h00;
    for (int i = 0; i < 640; i++) pld_mem[i] = 8'h00;

    // Reset values
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_req_ready", 32'(req_ready_o),  32'd0);
    check("rst_valid",     32'(byte_valid_o), 32'd0);
    check("rst_data",      32'(byte_data_o),  32'd0);
    check("rst_last",      32'(byte_last_o),  32'd0);
    check("rst_pld_ready", 32'(pld_ready_o),  32'd0);
    reset_n_i = 1'b1;
    cycles(1);
    check("rdy_after_rst", 32'(req_ready_o), 32'd1);
    mon_en = 1'b1;

    // Frame start short packet
    push_hdr(8'h00, 16'h0000, 8'h00, 1'b1);
    send_req(2'd0, 6'h00, 16'h0000);
    wait_drain("fs", 50);

    // RAW8 long packet, 4 bytes
    for (int i = 0; i < 4; i++) pld_mem[i] = 8'(i + 1);
    push_long(8'h2A, 16'h0004, 8'h33, exp_footer(4));
    fork
      send_req(2'd0, 6'h2A, 16'h0004);
      send_pld(4, 1'b0);
    join
    wait_drain("raw8", 50);

    // Header check wc=0x0280 (640 payload bytes)
    for (int i = 0; i < 640; i++) pld_mem[i] = 8'(i) ^ 8'hA5;
    push_long(8'h2A, 16'h0280, 8'h0E, exp_footer(640));
    fork
      send_req(2'd0, 6'h2A, 16'h0280);
      send_pld(640, 1'b0);
    join
    wait_drain("wc280", 50);

    // Known CRC vector, 24 bytes
    for (int i = 0; i < 24; i++) pld_mem[i] = vec24[i];
`ifdef MIPI_CSI_TX_CRC_EN
    f = 16'h00F0;
`else
    f = 16'h0000;
`endif
    push_long(8'h2A, 16'h0018, 8'h13, f);
    fork
      send_req(2'd0, 6'h2A, 16'h0018);
      send_pld(24, 1'b0);
    join
    wait_drain("crc24", 50);

    // Backpressure: 16-byte packet with random stalls on both sides
    for (int i = 0; i < 16; i++) pld_mem[i] = 8'(8'h30 + 8'(i * 7));
    push_long(8'h2B, 16'h0010, 8'h31, exp_footer(16));
    rdy_rand = 1'b1;
    fork
      send_req(2'd0, 6'h2B, 16'h0010);
      send_pld(16, 1'b1);
    join
    wait_drain("bp", 400);
    rdy_rand = 1'b0;
    cycles(1);

    // Long packet with wc=0; payload offered throughout must not be consumed
`ifdef MIPI_CSI_TX_CRC_EN
    f = 16'hFFFF;
`else
    f = 16'h0000;
`endif
    push_long(8'h2A, 16'h0000, 8'h10, f);
    pld_data_i  = 8'hEE;
    pld_valid_i = 1'b1;
    check("pld_ready_idle", 32'(pld_ready_o), 32'd0);
    send_req(2'd0, 6'h2A, 16'h0000);
    check("pld_ready_hdr", 32'(pld_ready_o), 32'd0);
    wait_drain("wc0", 50);
    pld_valid_i = 1'b0;

    // Reset asserted during PLD
    for (int i = 0; i < 16; i++) pld_mem[i] = 8'(8'hC0 + 8'(i));
    mon_en = 1'b0;
    fork
      send_req(2'd0, 6'h2A, 16'h0010);
      send_pld(16, 1'b0);
      begin
        cycles(8);
        check("pre_rst_pld_ready", 32'(pld_ready_o), 32'd1);
        check("pre_rst_valid",     32'(byte_valid_o), 32'd1);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("mid_rst_valid",     32'(byte_valid_o), 32'd0);
        check("mid_rst_data",      32'(byte_data_o),  32'd0);
        check("mid_rst_last",      32'(byte_last_o),  32'd0);
        check("mid_rst_pld_ready", 32'(pld_ready_o),  32'd0);
        check("mid_rst_req_ready", 32'(req_ready_o),  32'd0);
        abort = 1'b1;
        cycles(3);
      end
    join
    exp_q.delete();
    abort     = 1'b0;
    reset_n_i = 1'b1;
    mon_en    = 1'b1;
    cycles(1);
    check("rdy_after_rst2", 32'(req_ready_o), 32'd1);
    push_hdr(8'h41, 16'h1234, 8'h10, 1'b1);
    send_req(2'd1, 6'h01, 16'h1234);
    wait_drain("post_rst", 50);
    cycles(10);
    check("no_stale", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mipi_csi_tx_packet_builder.md
# mipi_csi_tx_packet_builder

Transmit-side CSI-2 low-level packet builder. It accepts a packet request (virtual channel, data type, word count) and computes the 6-bit header ECC. It serialises the packet as a byte stream: 4-byte header, then for long packets the payload bytes and a 2-byte footer. It sits between the TX application/pixel packer and the lane distribution stage, and produces headers that the RX header ECC decoder accepts with zero syndrome.

## Interface
Parameters:
- none

Ports (clock and reset first):
- `clk_i`  in  1  block clock
- `reset_n_i`  in  1  reset; asynchronous, active-low
- `req_valid_i`  in  1  packet request valid
- `req_ready_o`  out  1  request accepted when `req_valid_i && req_ready_o`
- `req_vc_i`  in  2  virtual channel ID
- `req_dt_i`  in  6  data type; 0x00–0x0F short packet, 0x10–0x3F long packet
- `req_wc_i`  in  16  word count (long), or short-packet data field
- `pld_valid_i`  in  1  payload byte valid
- `pld_ready_o`  out  1  payload byte accepted when both high
- `pld_data_i`  in  8  payload byte
- `byte_valid_o`  out  1  output byte valid
- `byte_ready_i`  in  1  downstream ready
- `byte_data_o`  out  8  output byte
- `byte_last_o`  out  1  marks final byte of the packet

## Operation
- Header word D[23:0] = {wc[15:8], wc[7:0], vc, dt}; DataID = D[7:0].
- ECC bits, where each bit is the XOR of the listed D bits:
  - ECC[0] = D 0,1,2,4,5,7,10,11,13,16,20,21,22,23
  - ECC[1] = D 0,1,3,4,6,8,10,12,14,17,20,21,22,23
  - ECC[2] = D 0,2,3,5,6,9,11,12,15,18,20,21,22
  - ECC[3] = D 1,2,3,7,8,9,13,14,15,19,20,21,23
  - ECC[4] = D 4,5,6,7,8,9,16,17,18,19,20,22,23
  - ECC[5] = D 10–19,21,22,23
  - ECC[7:6] = 0
- Byte order on the wire: DataID, WC LSB, WC MSB, ECC, then payload (long only), then CRC LSB, CRC MSB (long only).
- FSM states:
  - IDLE: `req_ready_o`=1. On accept, latch vc/dt/wc, compute ECC, byte index ←0, go to HDR.
  - HDR: emit 4 header bytes. After the ECC byte is accepted: short → IDLE; long with wc>0 → PLD; long with wc=0 → FTR.
  - PLD: 16-bit down-counter loaded with wc; each accepted payload byte decrements it. Accepting the byte at count 1 → FTR.
  - FTR: emit 2 footer bytes. After the second is accepted → IDLE.
- `byte_last_o`=1 only on the ECC byte of a short packet or the CRC MSB byte of a long packet.
- `req_ready_o`=0 outside IDLE. `pld_ready_o`=0 outside PLD. Payload offered outside PLD is ignored (not consumed).
- Reset mid-packet: FSM→IDLE, counters cleared, partial packet abandoned, no `byte_last_o`.

## Timing
- Output is a register stage. `byte_data_o`/`byte_last_o` are held stable while `byte_valid_o && !byte_ready_i`.
- Request accepted at cycle N → DataID valid at N+1. With `byte_ready_i`=1 throughout, header bytes are at N+1..N+4.
- PLD: pass-through through the output register, one byte per cycle at full throughput. `pld_ready_o` = PLD && (!`byte_valid_o` || `byte_ready_i`).
- Footer follows the last payload byte with no bubble.
- After the last byte is accepted, IDLE holds `req_ready_o`=1 in the next cycle, giving one idle cycle between packets.
- Reset values of all outputs: `req_ready_o`=0 during reset and 1 from the first clock after reset deassert; all other outputs 0.

## Configuration
- `MIPI_CSI_TX_CRC_EN` defined:
  - footer = CRC-16, polynomial x^16+x^12+x^5+1, reflected (0x8408), seed 0xFFFF, bytes processed LSB-first, no final XOR.
  - CRC reseeds at each request accept and is updated on each accepted payload byte.
- Not defined: footer bytes are 0x00, 0x00 (checksum not computed); no CRC logic is instantiated.
- All other behaviour is identical in both configurations.

## Test plan
- Frame start: vc=0, dt=0x00, wc=0x0000, ready always 1 → bytes 00 00 00 00, last on 4th byte, then IDLE.
- RAW8 long packet: vc=0, dt=0x2A, wc=0x0004, payload 01 02 03 04 → 2A 04 00 ECC, then 01 02 03 04, then footer with last on the final byte. Header check: wc=0x0280 yields 2A 80 02 0E.
- CRC (macro on): 24-byte payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01 → footer F0 00. With macro off → 00 00.
- Backpressure: random `byte_ready_i`/`pld_valid_i` stalls over a 16-byte packet → byte sequence unchanged, data held stable while stalled, no payload byte lost or duplicated.
- Long packet with wc=0 → header then footer (CRC = FF FF with macro on), 6 bytes total.
- Reset asserted during PLD → outputs 0 immediately. After release, a new short packet is emitted correctly and no stale bytes appear.
